// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port 1024x8 synchronous data RAM (port A = MEM stage, B = loader).
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise A has priority with a MAX_WAIT starvation guard.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       iReqA,
    input  logic       iWeA,
    input  logic [9:0] iAddrA,
    input  logic [7:0] iWDataA,
    input  logic       iReqB,
    input  logic       iWeB,
    input  logic [9:0] iAddrB,
    input  logic [7:0] iWDataB,
    output logic       oGntA,
    output logic       oGntB,
    output logic       oValidA,
    output logic       oValidB,
    output logic [7:0] oRDataA,
    output logic [7:0] oRDataB,
    output logic       oRamEn,
    output logic       oRamWe,
    output logic [9:0] oRamAddr,
    output logic [7:0] oRamWData,
    input  logic [7:0] iRamRData
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_A = 2'd1;
    localparam logic [1:0] SERVE_B = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_b_wins;
    logic       r_we;
    logic [9:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_tag_vld;
    logic       r_tag_b;
    logic       r_vld_a;
    logic       r_vld_b;
    logic [7:0] r_rdata_a;
    logic [7:0] r_rdata_b;

`ifdef DMEM_ARB_RR_EN
    logic r_last_b;

    // On contention the port not served last wins.
    assign w_b_wins = iReqB && (!iReqA || !r_last_b);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            r_last_b <= 1'b1;
        else if (iReqA || iReqB)
            r_last_b <= w_b_wins;
    end
`else
    logic [7:0] r_wait;

    // B is forced through once it has been refused MAX_WAIT edges in a row.
    assign w_b_wins = iReqB && (!iReqA || (r_wait == 8'(MAX_WAIT)));

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            r_wait <= 8'd0;
        else if (iReqB && !w_b_wins)
            r_wait <= r_wait + 8'd1;
        else
            r_wait <= 8'd0;
    end
`endif

    always_comb begin
        w_next = IDLE;
        if (w_b_wins)
            w_next = SERVE_B;
        else if (iReqA)
            w_next = SERVE_A;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= 10'd0;
            r_wdata <= 8'd0;
        end else begin
            r_state <= w_next;
            case (w_next)
                SERVE_A: begin
                    r_we    <= iWeA;
                    r_addr  <= iAddrA;
                    r_wdata <= iWDataA;
                end
                SERVE_B: begin
                    r_we    <= iWeB;
                    r_addr  <= iAddrB;
                    r_wdata <= iWDataB;
                end
                default: r_we <= 1'b0;
            endcase
        end
    end

    // Read tag follows the command one cycle, then steers RAM data to its port.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tag_vld <= 1'b0;
            r_tag_b   <= 1'b0;
            r_vld_a   <= 1'b0;
            r_vld_b   <= 1'b0;
            r_rdata_a <= 8'd0;
            r_rdata_b <= 8'd0;
        end else begin
            r_tag_vld <= (r_state != IDLE) && !r_we;
            r_tag_b   <= (r_state == SERVE_B);
            r_vld_a   <= r_tag_vld && !r_tag_b;
            r_vld_b   <= r_tag_vld && r_tag_b;
            if (r_tag_vld && !r_tag_b)
                r_rdata_a <= iRamRData;
            if (r_tag_vld && r_tag_b)
                r_rdata_b <= iRamRData;
        end
    end

    assign oGntA     = (r_state == SERVE_A);
    assign oGntB     = (r_state == SERVE_B);
    assign oRamEn    = (r_state != IDLE);
    assign oRamWe    = r_we;
    assign oRamAddr  = r_addr;
    assign oRamWData = r_wdata;
    assign oValidA   = r_vld_a;
    assign oValidB   = r_vld_b;
    assign oRDataA   = r_rdata_a;
    assign oRDataB   = r_rdata_b;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x8 synchronous RAM.
module tb_dmem_arbiter;
    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       iReqA, iWeA, iReqB, iWeB;
    logic [9:0] iAddrA, iAddrB;
    logic [7:0] iWDataA, iWDataB;
    logic       oGntA, oGntB, oValidA, oValidB;
    logic [7:0] oRDataA, oRDataB;
    logic       oRamEn, oRamWe;
    logic [9:0] oRamAddr;
    logic [7:0] oRamWData;
    logic [7:0] iRamRData;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [1024];
    logic [39:0] all_out;

    dmem_arbiter #(.MAX_WAIT(8)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .iReqA(iReqA), .iWeA(iWeA), .iAddrA(iAddrA), .iWDataA(iWDataA),
        .iReqB(iReqB), .iWeB(iWeB), .iAddrB(iAddrB), .iWDataB(iWDataB),
        .oGntA(oGntA), .oGntB(oGntB), .oValidA(oValidA), .oValidB(oValidB),
        .oRDataA(oRDataA), .oRDataB(oRDataB),
        .oRamEn(oRamEn), .oRamWe(oRamWe), .oRamAddr(oRamAddr), .oRamWData(oRamWData),
        .iRamRData(iRamRData)
    );

    always #5 Clock = ~Clock;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        iRamRData = 8'd0;
    end

    always @(posedge Clock) begin
        if (oRamEn) begin
            if (oRamWe) mem[oRamAddr] <= oRamWData;
            else        iRamRData <= mem[oRamAddr];
        end
    end

    assign all_out = {oGntA, oGntB, oValidA, oValidB, oRDataA, oRDataB,
                      oRamEn, oRamWe, oRamAddr, oRamWData};

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_reset;
        Reset_n = 1'b0;
        tick;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        #2;
        n_tests++;
        if (all_out !== 40'd0) begin n_fail++; $display("FAIL reset_async outputs=%h want 0", all_out); end
        tick; tick;
        Reset_n = 1'b1;
        tick;
        n_tests++;
        if (all_out !== 40'd0) begin n_fail++; $display("FAIL reset_idle outputs=%h want 0", all_out); end
    endtask

    task automatic test_write_read;
        iReqA = 1; iWeA = 1; iAddrA = 10'd1; iWDataA = 8'd9;
        tick;
        n_tests++;
        if ({oGntA, oGntB, oRamEn, oRamWe} !== 4'b1011) begin n_fail++; $display("FAIL wr_grant gntA/gntB/en/we=%b want 1011", {oGntA, oGntB, oRamEn, oRamWe}); end
        n_tests++;
        if (oRamAddr !== 10'd1 || oRamWData !== 8'd9) begin n_fail++; $display("FAIL wr_cmd addr=%0d data=%0d want 1/9", oRamAddr, oRamWData); end
        iWeA = 0;
        tick;
        n_tests++;
        if ({oGntA, oRamEn, oRamWe} !== 3'b110 || oRamAddr !== 10'd1) begin n_fail++; $display("FAIL rd_grant gnt/en/we=%b addr=%0d want 110/1", {oGntA, oRamEn, oRamWe}, oRamAddr); end
        iReqA = 0;
        tick;
        n_tests++;
        if ({oGntA, oValidA, oRamEn} !== 3'b000) begin n_fail++; $display("FAIL rd_gap gnt/valid/en=%b want 000", {oGntA, oValidA, oRamEn}); end
        tick;
        n_tests++;
        if (oValidA !== 1'b1 || oRDataA !== 8'd9) begin n_fail++; $display("FAIL rd_return valid=%b data=%0d want 1/9", oValidA, oRDataA); end
        tick;
        n_tests++;
        if (oValidA !== 1'b0 || oRDataA !== 8'd9) begin n_fail++; $display("FAIL rd_hold valid=%b data=%0d want 0/9", oValidA, oRDataA); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_d [3];
        exp_d[0] = 8'd9; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        iReqA = 1; iWeA = 1; iAddrA = 10'd2; iWDataA = 8'h22;
        tick;
        iAddrA = 10'd3; iWDataA = 8'h33;
        tick;
        n_tests++;
        if (oGntA !== 1'b1 || oRamAddr !== 10'd3) begin n_fail++; $display("FAIL b2b_wr gnt=%b addr=%0d want 1/3", oGntA, oRamAddr); end
        iReqA = 0;
        tick;
        for (int k = 0; k < 6; k++) begin
            iReqA = (k < 3); iWeA = 0; iAddrA = 10'(k + 1);
            tick;
            n_tests++;
            if (oGntA !== (k < 3)) begin n_fail++; $display("FAIL b2b_gnt[%0d] gnt=%b want %b", k, oGntA, (k < 3)); end
            n_tests++;
            if (oValidA !== (k >= 2 && k < 5)) begin n_fail++; $display("FAIL b2b_valid[%0d] valid=%b want %b", k, oValidA, (k >= 2 && k < 5)); end
            if (k >= 2 && k < 5) begin
                n_tests++;
                if (oRDataA !== exp_d[k-2]) begin n_fail++; $display("FAIL b2b_data[%0d] data=%h want %h", k, oRDataA, exp_d[k-2]); end
            end
        end
    endtask

    function automatic logic exp_b(int k);
`ifdef DMEM_ARB_RR_EN
        return (k % 2) == 1;
`else
        return (k % 9) == 8;
`endif
    endfunction

    task automatic test_priority;
        logic eb, vb;
        apply_reset;
        iReqA = 1; iWeA = 0; iAddrA = 10'd1;
        iReqB = 1; iWeB = 0; iAddrB = 10'd3;
        for (int k = 0; k < 20; k++) begin
            tick;
            eb = exp_b(k);
            vb = (k >= 2) && exp_b(k - 2);
            n_tests++;
            if (oGntA !== !eb || oGntB !== eb) begin n_fail++; $display("FAIL prio_gnt[%0d] gntA=%b gntB=%b want %b/%b", k, oGntA, oGntB, !eb, eb); end
            n_tests++;
            if (oValidB !== vb || oValidA !== (k >= 2 && !vb)) begin n_fail++; $display("FAIL prio_valid[%0d] vA=%b vB=%b want %b/%b", k, oValidA, oValidB, (k >= 2 && !vb), vb); end
            if (vb) begin
                n_tests++;
                if (oRDataB !== 8'h33) begin n_fail++; $display("FAIL prio_dataB[%0d] data=%h want 33", k, oRDataB); end
            end
        end
        iReqA = 0; iReqB = 0;
        tick; tick; tick;
    endtask

    task automatic test_reset_midop;
        iReqA = 1; iWeA = 0; iAddrA = 10'd1;
        tick;
        n_tests++;
        if (oGntA !== 1'b1) begin n_fail++; $display("FAIL midrst_grant gnt=%b want 1", oGntA); end
        iReqA = 0;
        tick;
        Reset_n = 1'b0;
        #1;
        n_tests++;
        if (all_out !== 40'd0) begin n_fail++; $display("FAIL midrst_outputs outputs=%h want 0", all_out); end
        tick; tick;
        Reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            n_tests++;
            if (oValidA !== 1'b0 || oGntA !== 1'b0) begin n_fail++; $display("FAIL midrst_after[%0d] valid=%b gnt=%b want 0/0", k, oValidA, oGntA); end
        end
    endtask

    task automatic test_b_write_a_read;
        iReqB = 1; iWeB = 1; iAddrB = 10'd2; iWDataB = 8'd15;
        tick;
        n_tests++;
        if ({oGntB, oRamWe} !== 2'b11 || oRamAddr !== 10'd2 || oRamWData !== 8'd15) begin n_fail++; $display("FAIL bwr_cmd gnt/we=%b addr=%0d data=%0d want 11/2/15", {oGntB, oRamWe}, oRamAddr, oRamWData); end
        iReqB = 0;
        iReqA = 1; iWeA = 0; iAddrA = 10'd2;
        tick;
        n_tests++;
        if (oGntA !== 1'b1) begin n_fail++; $display("FAIL bwr_agnt gnt=%b want 1", oGntA); end
        iReqA = 0;
        tick;
        n_tests++;
        if (oValidB !== 1'b0) begin n_fail++; $display("FAIL bwr_novalid validB=%b want 0", oValidB); end
        tick;
        n_tests++;
        if (oValidA !== 1'b1 || oRDataA !== 8'd15) begin n_fail++; $display("FAIL bwr_adata valid=%b data=%0d want 1/15", oValidA, oRDataA); end
    endtask

    // Read and write to the same address requested together: grant order decides the data.
    task automatic test_order;
        iReqA = 1; iWeA = 0; iAddrA = 10'd3;
        iReqB = 1; iWeB = 1; iAddrB = 10'd3; iWDataB = 8'h44;
        tick;
`ifdef DMEM_ARB_RR_EN
        n_tests++;
        if (oGntB !== 1'b1) begin n_fail++; $display("FAIL order_first gntB=%b want 1", oGntB); end
        iReqB = 0;
        tick;
        n_tests++;
        if (oGntA !== 1'b1) begin n_fail++; $display("FAIL order_second gntA=%b want 1", oGntA); end
        iReqA = 0;
        tick; tick;
        n_tests++;
        if (oValidA !== 1'b1 || oRDataA !== 8'h44) begin n_fail++; $display("FAIL order_data valid=%b data=%h want 1/44", oValidA, oRDataA); end
`else
        n_tests++;
        if (oGntA !== 1'b1) begin n_fail++; $display("FAIL order_first gntA=%b want 1", oGntA); end
        iReqA = 0;
        tick;
        n_tests++;
        if (oGntB !== 1'b1) begin n_fail++; $display("FAIL order_second gntB=%b want 1", oGntB); end
        iReqB = 0;
        tick;
        n_tests++;
        if (oValidA !== 1'b1 || oRDataA !== 8'h33) begin n_fail++; $display("FAIL order_data valid=%b data=%h want 1/33", oValidA, oRDataA); end
`endif
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset_n = 1'b0;
        iReqA = 0; iWeA = 0; iAddrA = '0; iWDataA = '0;
        iReqB = 0; iWeB = 0; iAddrB = '0; iWDataB = '0;
        test_reset;
        test_write_read;
        test_back_to_back;
        test_priority;
        test_reset_midop;
        test_b_write_a_read;
        test_order;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port 1024x8 synchronous data memory behind the MEM stage. It shares the RAM between the pipeline MEM stage (port A) and the loader/debug port (port B). It accepts one access per cycle and registers all RAM commands. It returns read data with a fixed latency and a valid strobe. Fixed priority with an anti-starvation guard is the default; a round-robin policy is selectable.

## Interface
Parameters:
- `MAX_WAIT`, default 8: consecutive cycles B may be refused while requesting before it is forced through (fixed-priority mode only); range 1..255.

Ports:
- `Clock`  in  1  single clock; all state changes on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `iReqA` / `iReqB`  in  1  access request.
- `iWeA` / `iWeB`  in  1  1 = write, 0 = read.
- `iAddrA` / `iAddrB`  in  10  word address.
- `iWDataA` / `iWDataB`  in  8  write data.
- `oGntA` / `oGntB`  out  1  one-cycle pulse: the request sampled on the previous edge was accepted.
- `oValidA` / `oValidB`  out  1  one-cycle pulse: `oRDataX` holds read data.
- `oRDataA` / `oRDataB`  out  8  read data; holds its last value otherwise.
- `oRamEn`  out  1  RAM command strobe.
- `oRamWe`  out  1  RAM write enable.
- `oRamAddr`  out  10  RAM address.
- `oRamWData`  out  8  RAM write data.
- `iRamRData`  in  8  RAM read data, valid the cycle after an `oRamEn` read.

## Operation
- State machine: `IDLE`, `SERVE_A`, `SERVE_B`.
  - On each edge, the sampled `iReqA`/`iReqB` select the next state: no request goes to `IDLE`, else the winner's state.
  - The command is registered: in `SERVE_X`, `oRamEn=1` and `oGntX=1`, and `oRamWe`/`oRamAddr`/`oRamWData` carry port X's sampled fields.
- Handshake:
  - The requester holds `iReqX` and its fields until it sees `oGntX`.
  - During the `oGntX` cycle, the requester must drop `iReqX` or present the next request. The values present at that cycle's end edge are a new request.
  - Back-to-back grants to the same port are therefore allowed, giving 1 access per cycle.
- Fixed priority (default): A wins when both request.
  - An 8-bit wait counter increments on each edge where B requests and loses.
  - It clears when B is granted or `iReqB=0`.
  - When the counter equals `MAX_WAIT`, B wins the next arbitration regardless of A.
- Read return:
  - A read-tag pipeline records the port of each read command.
  - One cycle after the command, `iRamRData` is captured into `oRDataX` and `oValidX` pulses.
- Writes produce no `oValidX`.
- A read and a write to the same address, in consecutive grants, return the data stored before the write only if the read was granted first. Ordering follows grant order; the RAM is not read-during-write bypassed.

## Timing
- Reset (asynchronous assert, synchronous release effect):
  - state `IDLE`, wait counter 0, read tags cleared.
  - All outputs 0: `oGntX`, `oValidX`, `oRDataX`, `oRamEn`, `oRamWe`, `oRamAddr`, `oRamWData`.
  - The last-served pointer is set to B.
- Latency, with the request sampled on edge E0:
  - grant and RAM command in cycle E0..E1.
  - RAM data in E1..E2.
  - `oValidX`/`oRDataX` in E2..E3: 3 cycles from request sample to valid.
- Reset asserted mid-operation aborts the in-flight command and discards pending read tags; no `oValidX` pulse follows release.
- Simultaneous new request and `oValid` for the same port are independent; both proceed.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - When both request, the port not served last wins.
  - The last-served pointer updates on every grant.
  - The wait counter and `MAX_WAIT` are unused, and the counter is compiled out.
- Undefined: fixed priority to A with the `MAX_WAIT` anti-starvation guard as described above.

## Test plan
- Single A write then A read: write addr 1 data 9, then read addr 1. Expect one `oGntA` pulse each, `oRamWe` 1 then 0, and `oValidA` with `oRDataA=9` 3 cycles after the read request.
- Back-to-back A stream of reads to addr 1, 2, 3 held continuously: expect `oGntA` high 3 consecutive cycles and 3 consecutive `oValidA` pulses in address order.
- Fixed priority, A and B requesting continuously, `MAX_WAIT=8`: expect 8 A grants, then 1 B grant, repeating; `oValidB` data matches the B address contents.
- `DMEM_ARB_RR_EN` build with both requesting continuously: grants alternate A, B, A, B, starting with A after reset.
- Reset_n pulled low the cycle after an A read grant: expect all outputs 0 immediately, and no `oValidA` after release.
- Write via B addr 2 data 15 granted before an A read of addr 2: expect `oRDataA=15`.
